quantum_scheduler: RTL and testbench

- Parametrised multiprogramming controller. Generalises the single-process quantum/context-switch logic to NUM_PROC processes.
- Adds a per-process saved-PC table, a ready mask and round-robin dispatch.
- Sits beside the datapath and drives the program counter's jump address and the memory shift selector.
- The OS dispatches processes. The block preempts on quantum expiry, or on halt, and returns control to the OS entry address.

---
 rtl/quantum_scheduler_pkg.sv | 12 +
 rtl/quantum_scheduler_if.sv | 25 ++
 rtl/quantum_scheduler_rr_pick.sv | 24 ++
 rtl/quantum_scheduler.sv | 163 ++++++++++++++++
 tb/tb_quantum_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quantum_scheduler_pkg.sv
// Shared types and constants for the multiprogramming quantum scheduler.
package quantum_sched_pkg;

  typedef enum logic {ST_OS, ST_RUN} schedState;

  localparam logic [1:0] SHIFT_HOLD = 2'd0;
  localparam logic [1:0] SHIFT_OS   = 2'd1;
  localparam logic [1:0] SHIFT_PROC = 2'd2;

  localparam int unsigned QUANTUM_DEFAULT = 500000;

endpackage

// File: rtl/quantum_scheduler_if.sv
// Datapath-side handshake between the scheduler and the PC / memory shifter.
interface quantum_scheduler_if #(
  parameter int ADDR_W = 12
);

  logic              dispatch;
  logic              halt;
  logic [ADDR_W-1:0] pc_cur;
  logic              pc_stall;
  logic [ADDR_W-1:0] new_addr;
  logic              jump;
  logic              cs_req;
  logic [1:0]        shift_ctrl;

  modport master (
    output dispatch, halt, pc_cur, pc_stall,
    input  new_addr, jump, cs_req, shift_ctrl
  );

  modport slave (
    input  dispatch, halt, pc_cur, pc_stall,
    output new_addr, jump, cs_req, shift_ctrl
  );

endinterface

// File: rtl/quantum_scheduler_rr_pick.sv
// Round-robin first-set finder: first ready slot strictly after rrPtr, wrapping.
module rr_pick #(
  parameter int NUM_PROC = 4,
  parameter int PID_W    = 2
) (
  input  logic [NUM_PROC-1:0] readyMask,
  input  logic [PID_W-1:0]    rrPtr,
  output logic [PID_W-1:0]    pick,
  output logic                any
);

  always_comb begin
    pick = '0;
    any  = 1'b0;
    // i == NUM_PROC lands back on rrPtr itself, so it is considered last
    for (int i = 1; i <= NUM_PROC; i++) begin
      if (!any && readyMask[(int'(rrPtr) + i) % NUM_PROC]) begin
        any  = 1'b1;
        pick = PID_W'((int'(rrPtr) + i) % NUM_PROC);
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Multiprogramming controller: per-process PC table, ready mask, round-robin dispatch, quantum preemption.
// Optional context-switch statistics counter under `QUANTUM_SCHED_STATS_EN.
//   state  | meaning
//   ST_OS  | OS code running; waits for dispatch of a ready slot
//   ST_RUN | process cur_pid running; counts quantum, watches halt
module quantum_scheduler
  import quantum_sched_pkg::*;
#(
  parameter int          NUM_PROC    = 4,
  parameter int          ADDR_W      = 12,
  parameter int          QUANTUM_W   = 32,
  parameter int unsigned QUANTUM_RST = QUANTUM_DEFAULT,
  parameter int          PID_W       = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_quantum_we,
  input  logic [QUANTUM_W-1:0] cfg_quantum,
  input  logic                 cfg_mp_we,
  input  logic                 cfg_mp,
  input  logic                 cfg_os_we,
  input  logic [ADDR_W-1:0]    cfg_os_addr,
  input  logic                 load_we,
  input  logic [PID_W-1:0]     load_pid,
  input  logic [ADDR_W-1:0]    load_pc,
  quantum_scheduler_if.slave   bus,
  output logic [PID_W-1:0]     cur_pid,
  output logic [ADDR_W-1:0]    saved_pc,
  output logic [NUM_PROC-1:0]  ready_mask,
  output logic                 all_done,
  output logic [15:0]          cs_count
);

  schedState            state;
  logic [QUANTUM_W-1:0] quantumReg;
  logic                 mpReg;
  logic [ADDR_W-1:0]    osAddr;
  logic [ADDR_W-1:0]    pcTable [NUM_PROC];
  logic [NUM_PROC-1:0]  readyReg;
  logic [PID_W-1:0]     curPid;
  logic [PID_W-1:0]     rrPtr;
  logic [QUANTUM_W-1:0] count;
  logic [ADDR_W-1:0]    newAddrReg;
  logic                 jumpReg;
  logic                 csReqReg;
  logic [1:0]           shiftReg;
  logic [PID_W-1:0]     rrNext;
  logic                 rrAny;
  logic                 expire;

  rr_pick #(
    .NUM_PROC (NUM_PROC),
    .PID_W    (PID_W)
  ) u_rr_pick (
    .readyMask (readyReg),
    .rrPtr     (rrPtr),
    .pick      (rrNext),
    .any       (rrAny)
  );

  // >= rather than == so a quantum shrunk below the running count still expires
  assign expire = (state == ST_RUN) && mpReg && !bus.pc_stall &&
                  (count >= quantumReg - QUANTUM_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_OS;
      quantumReg <= QUANTUM_W'(QUANTUM_RST);
      mpReg      <= 1'b0;
      osAddr     <= '0;
      for (int i = 0; i < NUM_PROC; i++) pcTable[i] <= '0;
      readyReg   <= '0;
      curPid     <= '0;
      rrPtr      <= PID_W'(NUM_PROC - 1);
      count      <= '0;
      newAddrReg <= '0;
      jumpReg    <= 1'b0;
      csReqReg   <= 1'b0;
      shiftReg   <= SHIFT_HOLD;
    end else begin
      jumpReg  <= 1'b0;
      csReqReg <= 1'b0;
      shiftReg <= SHIFT_HOLD;

      if (cfg_quantum_we) quantumReg <= (cfg_quantum == '0) ? QUANTUM_W'(1) : cfg_quantum;
      if (cfg_mp_we)      mpReg      <= cfg_mp;
      if (cfg_os_we)      osAddr     <= cfg_os_addr;

      case (state)
        ST_OS: begin
          if (bus.dispatch && rrAny) begin
            curPid     <= rrNext;
            rrPtr      <= rrNext;
            newAddrReg <= pcTable[rrNext];
            jumpReg    <= 1'b1;
            shiftReg   <= SHIFT_PROC;
            count      <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.halt) begin
            readyReg[curPid] <= 1'b0;
            pcTable[curPid]  <= bus.pc_cur;
            newAddrReg       <= mpReg ? osAddr : '0;
            jumpReg          <= 1'b1;
            shiftReg         <= SHIFT_OS;
            count            <= '0;
            state            <= ST_OS;
          end else if (expire) begin
            pcTable[curPid] <= bus.pc_cur;
            csReqReg        <= 1'b1;
            newAddrReg      <= osAddr;
            jumpReg         <= 1'b1;
            shiftReg        <= SHIFT_OS;
            count           <= '0;
            state           <= ST_OS;
          end else if (!mpReg) begin
            count <= '0;
          end else if (!bus.pc_stall) begin
            count <= count + QUANTUM_W'(1);
          end
        end
        default: state <= ST_OS;
      endcase

      // Placed last so a table load overrides a same-cycle save/clear of that slot
      if (load_we) begin
        pcTable[load_pid]  <= load_pc;
        readyReg[load_pid] <= 1'b1;
      end
    end
  end

`ifdef QUANTUM_SCHED_STATS_EN
  logic        switchFire;
  logic [15:0] csCnt;

  assign switchFire = (state == ST_RUN) && (bus.halt || expire);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csCnt <= '0;
    end else if (switchFire && (csCnt != 16'hFFFF)) begin
      csCnt <= csCnt + 16'd1;
    end
  end

  assign cs_count = csCnt;
`else
  assign cs_count = 16'd0;
`endif

  assign bus.new_addr   = newAddrReg;
  assign bus.jump       = jumpReg;
  assign bus.cs_req     = csReqReg;
  assign bus.shift_ctrl = shiftReg;
  assign cur_pid        = curPid;
  assign saved_pc       = pcTable[curPid];
  assign ready_mask     = readyReg;
  assign all_done       = (readyReg == '0);

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed, table-driven bench for quantum_scheduler (NUM_PROC=4, ADDR_W=12).
module tb_quantum_scheduler;
  import quantum_sched_pkg::*;

`ifdef QUANTUM_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cfgQuantumWe;
  logic [31:0] cfgQuantum;
  logic        cfgMpWe;
  logic        cfgMp;
  logic        cfgOsWe;
  logic [11:0] cfgOsAddr;
  logic        loadWe;
  logic [1:0]  loadPid;
  logic [11:0] loadPc;
  logic [1:0]  curPid;
  logic [11:0] savedPc;
  logic [3:0]  readyMask;
  logic        allDone;
  logic [15:0] csCount;

  int errors = 0;
  int checks = 0;
  int expSw  = 0;
  int pulses;

  quantum_scheduler_if #(.ADDR_W(12)) bus ();

  quantum_scheduler #(
    .NUM_PROC  (4),
    .ADDR_W    (12),
    .QUANTUM_W (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_quantum_we (cfgQuantumWe),
    .cfg_quantum    (cfgQuantum),
    .cfg_mp_we      (cfgMpWe),
    .cfg_mp         (cfgMp),
    .cfg_os_we      (cfgOsWe),
    .cfg_os_addr    (cfgOsAddr),
    .load_we        (loadWe),
    .load_pid       (loadPid),
    .load_pc        (loadPc),
    .bus            (bus),
    .cur_pid        (curPid),
    .saved_pc       (savedPc),
    .ready_mask     (readyMask),
    .all_done       (allDone),
    .cs_count       (csCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ldWe;
    logic [1:0]  ldPid;
    logic [11:0] ldPc;
    logic        cfg;     // mp=1, quantum=4, os_addr=0x010 in one cycle
    logic        disp;
    logic        hlt;
    logic        stall;
    logic [11:0] pc;
    logic        eJump;
    logic        eCs;
    logic [1:0]  eShift;
    logic [11:0] eAddr;
    logic [1:0]  ePid;
    logic [3:0]  eReady;
    logic [11:0] eSaved;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(input logic ldWe, input logic [1:0] ldPid, input logic [11:0] ldPc,
                              input logic cfg, input logic disp, input logic hlt, input logic stall,
                              input logic [11:0] pc, input logic eJ, input logic eCs,
                              input logic [1:0] eSh, input logic [11:0] eA, input logic [1:0] eP,
                              input logic [3:0] eR, input logic [11:0] eS);
    vec_t v;
    v.ldWe = ldWe;  v.ldPid = ldPid; v.ldPc = ldPc; v.cfg = cfg;
    v.disp = disp;  v.hlt = hlt;     v.stall = stall; v.pc = pc;
    v.eJump = eJ;   v.eCs = eCs;     v.eShift = eSh;  v.eAddr = eA;
    v.ePid = eP;    v.eReady = eR;   v.eSaved = eS;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkOut(input string tag, input int idx, input logic eJ, input logic eCs,
                          input logic [1:0] eSh, input logic [11:0] eA, input logic [1:0] eP,
                          input logic [3:0] eR, input logic [11:0] eS);
    chk({tag, ".jump"},       idx, 32'(bus.jump),       32'(eJ));
    chk({tag, ".cs_req"},     idx, 32'(bus.cs_req),     32'(eCs));
    chk({tag, ".shift_ctrl"}, idx, 32'(bus.shift_ctrl), 32'(eSh));
    chk({tag, ".new_addr"},   idx, 32'(bus.new_addr),   32'(eA));
    chk({tag, ".cur_pid"},    idx, 32'(curPid),         32'(eP));
    chk({tag, ".ready_mask"}, idx, 32'(readyMask),      32'(eR));
    chk({tag, ".saved_pc"},   idx, 32'(savedPc),        32'(eS));
    chk({tag, ".all_done"},   idx, 32'(allDone),        32'(eR == 4'b0000));
    chk({tag, ".cs_count"},   idx, 32'(csCount),        STATS ? 32'(expSw) : 32'd0);
  endtask

  task automatic idle();
    cfgQuantumWe = 1'b0; cfgQuantum = 32'd0;
    cfgMpWe = 1'b0;      cfgMp = 1'b0;
    cfgOsWe = 1'b0;      cfgOsAddr = 12'h000;
    loadWe = 1'b0;       loadPid = 2'd0; loadPc = 12'h000;
    bus.dispatch = 1'b0; bus.halt = 1'b0; bus.pc_stall = 1'b0; bus.pc_cur = 12'h000;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               ld pid  pc      cfg dsp hlt stl pc       J Cs Sh A        P   R        S
    vecs[0]  = mk(1, 2'd0, 12'h100, 1, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 2'd0, 4'b0001, 12'h100);
    vecs[1]  = mk(1, 2'd2, 12'h200, 0, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 2'd0, 4'b0101, 12'h100);
    vecs[2]  = mk(0, 2'd0, 12'h000, 0, 1, 0, 0, 12'h000, 1, 0, 2, 12'h100, 2'd0, 4'b0101, 12'h100);
    vecs[3]  = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h101, 0, 0, 0, 12'h100, 2'd0, 4'b0101, 12'h100);
    vecs[4]  = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h102, 0, 0, 0, 12'h100, 2'd0, 4'b0101, 12'h100);
    vecs[5]  = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h103, 0, 0, 0, 12'h100, 2'd0, 4'b0101, 12'h100);
    vecs[6]  = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h104, 1, 1, 1, 12'h010, 2'd0, 4'b0101, 12'h104);
    vecs[7]  = mk(0, 2'd0, 12'h000, 0, 1, 0, 0, 12'h000, 1, 0, 2, 12'h200, 2'd2, 4'b0101, 12'h200);
    vecs[8]  = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h201, 0, 0, 0, 12'h200, 2'd2, 4'b0101, 12'h200);
    vecs[9]  = mk(0, 2'd0, 12'h000, 0, 0, 0, 1, 12'h202, 0, 0, 0, 12'h200, 2'd2, 4'b0101, 12'h200);
    vecs[10] = mk(0, 2'd0, 12'h000, 0, 0, 0, 1, 12'h202, 0, 0, 0, 12'h200, 2'd2, 4'b0101, 12'h200);
    vecs[11] = mk(0, 2'd0, 12'h000, 0, 0, 0, 1, 12'h202, 0, 0, 0, 12'h200, 2'd2, 4'b0101, 12'h200);
    vecs[12] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h202, 0, 0, 0, 12'h200, 2'd2, 4'b0101, 12'h200);
    vecs[13] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h204, 0, 0, 0, 12'h200, 2'd2, 4'b0101, 12'h200);
    vecs[14] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h208, 1, 1, 1, 12'h010, 2'd2, 4'b0101, 12'h208);
    vecs[15] = mk(0, 2'd0, 12'h000, 0, 1, 0, 0, 12'h000, 1, 0, 2, 12'h104, 2'd0, 4'b0101, 12'h104);
    vecs[16] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h108, 0, 0, 0, 12'h104, 2'd0, 4'b0101, 12'h104);
    vecs[17] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h10C, 0, 0, 0, 12'h104, 2'd0, 4'b0101, 12'h104);
    vecs[18] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h10E, 0, 0, 0, 12'h104, 2'd0, 4'b0101, 12'h104);
    vecs[19] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h110, 1, 1, 1, 12'h010, 2'd0, 4'b0101, 12'h110);
    vecs[20] = mk(0, 2'd0, 12'h000, 0, 1, 0, 0, 12'h000, 1, 0, 2, 12'h208, 2'd2, 4'b0101, 12'h208);
    vecs[21] = mk(0, 2'd0, 12'h000, 0, 0, 1, 0, 12'h20C, 1, 0, 1, 12'h010, 2'd2, 4'b0001, 12'h20C);
    vecs[22] = mk(0, 2'd0, 12'h000, 0, 1, 0, 0, 12'h000, 1, 0, 2, 12'h110, 2'd0, 4'b0001, 12'h110);
    vecs[23] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h114, 0, 0, 0, 12'h110, 2'd0, 4'b0001, 12'h110);
    vecs[24] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h114, 0, 0, 0, 12'h110, 2'd0, 4'b0001, 12'h110);
    vecs[25] = mk(0, 2'd0, 12'h000, 0, 0, 0, 0, 12'h114, 0, 0, 0, 12'h110, 2'd0, 4'b0001, 12'h110);
    vecs[26] = mk(0, 2'd0, 12'h000, 0, 0, 1, 0, 12'h118, 1, 0, 1, 12'h010, 2'd0, 4'b0000, 12'h118);
    vecs[27] = mk(0, 2'd0, 12'h000, 0, 1, 0, 0, 12'h000, 0, 0, 0, 12'h010, 2'd0, 4'b0000, 12'h118);

    idle();
    reset = 1'b0;
    #12;
    checkOut("reset", 0, 0, 0, 0, 12'h000, 2'd0, 4'b0000, 12'h000);
    reset = 1'b1;
    tick();
    checkOut("reset_idle", 0, 0, 0, 0, 12'h000, 2'd0, 4'b0000, 12'h000);

    for (int i = 0; i < 28; i++) begin
      idle();
      loadWe = vecs[i].ldWe; loadPid = vecs[i].ldPid; loadPc = vecs[i].ldPc;
      if (vecs[i].cfg) begin
        cfgMpWe = 1'b1;      cfgMp = 1'b1;
        cfgQuantumWe = 1'b1; cfgQuantum = 32'd4;
        cfgOsWe = 1'b1;      cfgOsAddr = 12'h010;
      end
      bus.dispatch = vecs[i].disp;
      bus.halt     = vecs[i].hlt;
      bus.pc_stall = vecs[i].stall;
      bus.pc_cur   = vecs[i].pc;
      tick();
      if (vecs[i].eShift == SHIFT_OS) expSw++;
      checkOut("vec", i, vecs[i].eJump, vecs[i].eCs, vecs[i].eShift, vecs[i].eAddr,
               vecs[i].ePid, vecs[i].eReady, vecs[i].eSaved);
    end
    idle();

    // mp=0: no preemption over a long run, halt returns to address 0, empty dispatch ignored
    loadWe = 1'b1; loadPid = 2'd0; loadPc = 12'h050; cfgMpWe = 1'b1; cfgMp = 1'b0;
    tick(); idle();
    checkOut("mp0_load", 0, 0, 0, 0, 12'h010, 2'd0, 4'b0001, 12'h050);
    bus.dispatch = 1'b1;
    tick(); idle();
    checkOut("mp0_disp", 0, 1, 0, 2, 12'h050, 2'd0, 4'b0001, 12'h050);
    pulses = 0;
    bus.pc_cur = 12'h060;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (bus.cs_req || bus.jump) pulses++;
    end
    chk("mp0_no_preempt", 0, 32'(pulses), 32'd0);
    bus.halt = 1'b1; bus.pc_cur = 12'h07F;
    tick(); idle();
    expSw++;
    checkOut("mp0_halt", 0, 1, 0, 1, 12'h000, 2'd0, 4'b0000, 12'h07F);
    bus.dispatch = 1'b1;
    tick(); idle();
    checkOut("empty_disp", 0, 0, 0, 0, 12'h000, 2'd0, 4'b0000, 12'h07F);

    // table load to the running slot in the same cycle as its halt
    loadWe = 1'b1; loadPid = 2'd1; loadPc = 12'h400;
    tick(); idle();
    checkOut("ld1", 0, 0, 0, 0, 12'h000, 2'd0, 4'b0010, 12'h07F);
    bus.dispatch = 1'b1;
    tick(); idle();
    checkOut("disp1", 0, 1, 0, 2, 12'h400, 2'd1, 4'b0010, 12'h400);
    bus.pc_cur = 12'h404;
    tick(); idle();
    checkOut("run1", 0, 0, 0, 0, 12'h400, 2'd1, 4'b0010, 12'h400);
    bus.halt = 1'b1; bus.pc_cur = 12'h408;
    loadWe = 1'b1; loadPid = 2'd1; loadPc = 12'h480;
    tick(); idle();
    expSw++;
    checkOut("halt_load", 0, 1, 0, 1, 12'h000, 2'd1, 4'b0010, 12'h480);

    // quantum 0 acts as 1; several config writes in one cycle
    cfgMpWe = 1'b1; cfgMp = 1'b1; cfgQuantumWe = 1'b1; cfgQuantum = 32'd0;
    tick(); idle();
    bus.dispatch = 1'b1;
    tick(); idle();
    checkOut("q0_disp", 0, 1, 0, 2, 12'h480, 2'd1, 4'b0010, 12'h480);
    bus.pc_cur = 12'h490;
    tick(); idle();
    expSw++;
    checkOut("q0_expire", 0, 1, 1, 1, 12'h010, 2'd1, 4'b0010, 12'h490);

    // quantum shrunk below the running count mid-slice
    bus.dispatch = 1'b1; cfgQuantumWe = 1'b1; cfgQuantum = 32'd10;
    tick(); idle();
    checkOut("q10_disp", 0, 1, 0, 2, 12'h490, 2'd1, 4'b0010, 12'h490);
    for (int k = 0; k < 4; k++) begin
      bus.pc_cur = 12'h4A0;
      tick();
      checkOut("q10_run", k, 0, 0, 0, 12'h490, 2'd1, 4'b0010, 12'h490);
    end
    idle();
    bus.pc_cur = 12'h4A0; cfgQuantumWe = 1'b1; cfgQuantum = 32'd2;
    tick(); idle();
    checkOut("qshrink_wr", 0, 0, 0, 0, 12'h490, 2'd1, 4'b0010, 12'h490);
    bus.pc_cur = 12'h4B4;
    tick(); idle();
    expSw++;
    checkOut("qshrink_expire", 0, 1, 1, 1, 12'h010, 2'd1, 4'b0010, 12'h4B4);

    // asynchronous reset in the middle of a slice
    bus.dispatch = 1'b1;
    tick(); idle();
    checkOut("rst_disp", 0, 1, 0, 2, 12'h4B4, 2'd1, 4'b0010, 12'h4B4);
    bus.pc_cur = 12'h4B8;
    tick();
    reset = 1'b0;
    #1;
    expSw = 0;
    checkOut("rst_async", 0, 0, 0, 0, 12'h000, 2'd0, 4'b0000, 12'h000);
    #2;
    reset = 1'b1;
    idle();
    bus.dispatch = 1'b1;
    tick(); idle();
    checkOut("rst_after", 0, 0, 0, 0, 12'h000, 2'd0, 4'b0000, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
